alu_packet_engine: RTL and testbench

ALU_PACKET_ENGINE -- requirements
Module: alu_packet_engine

---
 rtl/alu_packet_engine_pkg.sv | 26 ++
 rtl/alu_packet_engine_if.sv | 19 +
 rtl/alu_packet_engine_divider.sv | 83 ++++++++
 rtl/alu_packet_engine.sv | 206 ++++++++++++++++++++
 tb/tb_alu_packet_engine.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_packet_engine_pkg.sv
// Shared opcodes, framing constants and FSM state type for the ALU packet engine.
package alu_pkg;

    typedef enum logic [7:0] {
        OP_ADD = 8'hAD,
        OP_SUB = 8'h3B,
        OP_MUL = 8'h63,
        OP_DIV = 8'h5B
    } opcode_e;

    typedef enum logic [3:0] {
        IDLE,
        HDR_RSV,
        HDR_LEN0,
        HDR_LEN1,
        PAYLOAD,
        DRAIN,
        DIVIDE,
        RESP,
        ERR
    } state_e;

    localparam logic [7:0]  ERR_BYTE  = 8'hEE;
    localparam int unsigned HDR_BYTES = 4;

endpackage

// File: rtl/alu_packet_engine_if.sv
// Request/response byte streams of the ALU packet engine.
interface alu_packet_engine_if;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid
    );
endinterface

// File: rtl/alu_packet_engine_divider.sv
// Iterative signed restoring divider: start/done handshake, done WIDTH+1 cycles after start.
module alu_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_den;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_abs_a = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign w_abs_b = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;
    // Dividend magnitude shifts out of r_quo MSB-first while quotient bits fill from the LSB.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_den};
    assign o_done  = r_done;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_den       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                if (i_divisor == '0) begin
                    o_quotient  <= '1;
                    o_remainder <= i_dividend;
                    r_done      <= 1'b1;
                end else begin
                    r_busy  <= 1'b1;
                    r_cnt   <= CW'(WIDTH);
                    r_rem   <= '0;
                    r_quo   <= w_abs_a;
                    r_den   <= w_abs_b;
                    r_neg_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                    r_neg_r <= i_dividend[WIDTH-1];
                end
            end else if (r_busy) begin
                if (r_cnt == '0) begin
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    o_quotient  <= r_neg_q ? -r_quo : r_quo;
                    o_remainder <= r_neg_r ? -r_rem : r_rem;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                    if (!w_diff[WIDTH]) begin
                        r_rem <= w_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: rtl/alu_packet_engine.sv
// Packet-based ALU: parses opcode/length framed requests, folds operands, streams the result.
// Define ALU_DIV_EN to support the signed DIV opcode and instantiate alu_divider.
module alu_packet_engine
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned MAX_OPERANDS = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_packet_engine_if.slave  axis,
    output logic                busy_o
);
    localparam int unsigned BYTES = WIDTH / 8;

    state_e             r_state;
    logic [7:0]         r_opcode;
    logic               r_rsv_bad;
    logic [7:0]         r_len_lo;
    logic [15:0]        r_cnt;
    logic [3:0]         r_sub;
    logic               r_first;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-9:0]   r_opnd;
    logic [2*WIDTH-1:0] r_resp;
    logic [4:0]         r_resp_cnt;
    logic               r_s_tready;
    logic               r_m_tvalid;

    logic               w_s_fire;
    logic               w_m_fire;
    logic [15:0]        w_len;
    logic               w_len_ok;
    logic               w_op_known;
    logic [WIDTH-1:0]   w_operand;
    logic [WIDTH-1:0]   w_fold;

    assign w_s_fire  = axis.s_axis_tvalid & r_s_tready;
    assign w_m_fire  = r_m_tvalid & axis.m_axis_tready;
    assign w_len     = {axis.s_axis_tdata, r_len_lo};
    assign w_operand = {axis.s_axis_tdata, r_opnd};

    assign axis.s_axis_tready = r_s_tready;
    assign axis.m_axis_tvalid = r_m_tvalid;
    assign axis.m_axis_tdata  = r_resp[7:0];
    assign busy_o             = (r_state != IDLE);

    always_comb begin
        w_len_ok = 1'b0;
        for (int unsigned n = 2; n <= MAX_OPERANDS; n++) begin
            if (w_len == 16'(HDR_BYTES + n * BYTES)) w_len_ok = 1'b1;
        end
        w_op_known = (r_opcode == OP_ADD) || (r_opcode == OP_SUB) || (r_opcode == OP_MUL);
`ifdef ALU_DIV_EN
        if (r_opcode == OP_DIV) begin
            w_len_ok   = (w_len == 16'(HDR_BYTES + 2 * BYTES));
            w_op_known = 1'b1;
        end
`endif
    end

    always_comb begin
        w_fold = r_acc;
        if (r_first) begin
            w_fold = w_operand;
        end else begin
            case (r_opcode)
                OP_ADD:  w_fold = r_acc + w_operand;
                OP_SUB:  w_fold = r_acc - w_operand;
                OP_MUL:  w_fold = r_acc * w_operand;
                default: w_fold = r_acc;
            endcase
        end
    end

`ifdef ALU_DIV_EN
    logic             w_div_start;
    logic             w_div_done;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // r_acc still holds operand 0 when the divisor's last byte arrives.
    assign w_div_start = (r_state == PAYLOAD) && w_s_fire && (r_cnt == 16'd1) && (r_opcode == OP_DIV);

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_start     (w_div_start),
        .i_dividend  (r_acc),
        .i_divisor   (w_operand),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_opcode   <= '0;
            r_rsv_bad  <= 1'b0;
            r_len_lo   <= '0;
            r_cnt      <= '0;
            r_sub      <= '0;
            r_first    <= 1'b0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_resp     <= '0;
            r_resp_cnt <= '0;
            r_s_tready <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_s_tready <= 1'b1;
                    if (w_s_fire) begin
                        r_opcode <= axis.s_axis_tdata;
                        r_state  <= HDR_RSV;
                    end
                end
                HDR_RSV: if (w_s_fire) begin
                    r_rsv_bad <= (axis.s_axis_tdata != 8'h00);
                    r_state   <= HDR_LEN0;
                end
                HDR_LEN0: if (w_s_fire) begin
                    r_len_lo <= axis.s_axis_tdata;
                    r_state  <= HDR_LEN1;
                end
                HDR_LEN1: if (w_s_fire) begin
                    r_cnt   <= w_len - 16'(HDR_BYTES);
                    r_sub   <= '0;
                    r_first <= 1'b1;
                    r_acc   <= '0;
                    if (!w_len_ok) begin
                        r_state    <= ERR;
                        r_s_tready <= 1'b0;
                        r_m_tvalid <= 1'b1;
                        r_resp     <= {{(2*WIDTH-8){1'b0}}, ERR_BYTE};
                        r_resp_cnt <= 5'd1;
                    end else if (w_op_known && !r_rsv_bad) begin
                        r_state <= PAYLOAD;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                PAYLOAD: if (w_s_fire) begin
                    r_cnt  <= r_cnt - 16'd1;
                    r_opnd <= w_operand[WIDTH-1:8];
                    if (r_sub == 4'(BYTES - 1)) begin
                        r_sub   <= '0;
                        r_first <= 1'b0;
                        r_acc   <= w_fold;
                    end else begin
                        r_sub <= r_sub + 4'd1;
                    end
                    if (r_cnt == 16'd1) begin
                        r_s_tready <= 1'b0;
                        r_state    <= RESP;
                        r_m_tvalid <= 1'b1;
                        r_resp     <= {{WIDTH{1'b0}}, w_fold};
                        r_resp_cnt <= 5'(BYTES);
`ifdef ALU_DIV_EN
                        if (r_opcode == OP_DIV) begin
                            r_state    <= DIVIDE;
                            r_m_tvalid <= 1'b0;
                        end
`endif
                    end
                end
                DRAIN: if (w_s_fire) begin
                    r_cnt <= r_cnt - 16'd1;
                    if (r_cnt == 16'd1) begin
                        r_state    <= ERR;
                        r_s_tready <= 1'b0;
                        r_m_tvalid <= 1'b1;
                        r_resp     <= {{(2*WIDTH-8){1'b0}}, ERR_BYTE};
                        r_resp_cnt <= 5'd1;
                    end
                end
`ifdef ALU_DIV_EN
                DIVIDE: if (w_div_done) begin
                    r_state    <= RESP;
                    r_m_tvalid <= 1'b1;
                    r_resp     <= {w_rem, w_quo};
                    r_resp_cnt <= 5'(2 * BYTES);
                end
`endif
                RESP, ERR: if (w_m_fire) begin
                    if (r_resp_cnt == 5'd1) begin
                        r_state    <= IDLE;
                        r_m_tvalid <= 1'b0;
                        r_s_tready <= 1'b1;
                    end else begin
                        r_resp     <= {8'h00, r_resp[2*WIDTH-1:8]};
                        r_resp_cnt <= r_resp_cnt - 5'd1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_s_tready <= 1'b1;
                    r_m_tvalid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_packet_engine.sv
// Self-checking bench for alu_packet_engine (WIDTH=32); DIV expectations follow ALU_DIV_EN.
module tb_alu_packet_engine;
    localparam int unsigned W   = 32;
    localparam int unsigned B   = W / 8;
    localparam int unsigned MAX = 6;
`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef logic [7:0]  q8_t[$];
    typedef logic [31:0] q32_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    alu_packet_engine_if axis_if ();

    alu_packet_engine #(.WIDTH(W), .MAX_OPERANDS(MAX)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .axis   (axis_if),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: framing rules and arithmetic straight from the packet definition.
    function automatic void model(input logic [7:0] op, input logic [7:0] rsv, input logic [15:0] len,
                                  input q32_t ops, output bit len_ok, output q8_t resp);
        int unsigned n;
        bit          known;
        logic [31:0] acc, q, r;
        int          a, b;
        resp   = {};
        len_ok = (len >= 4) && ((len - 4) % B == 0) && ((len - 4) / B >= 2) && ((len - 4) / B <= MAX);
        if (op == 8'h5B && DIV_EN) len_ok = (len == 16'(4 + 2 * B));
        known = (op == 8'hAD) || (op == 8'h3B) || (op == 8'h63) || (op == 8'h5B && DIV_EN);
        if (!len_ok || !known || rsv != 8'h00) begin
            resp.push_back(8'hEE);
            return;
        end
        n = (len - 4) / B;
        if (op == 8'h5B) begin
            a = int'(ops[0]);
            b = int'(ops[1]);
            if (b == 0) begin
                q = 32'hFFFF_FFFF;
                r = ops[0];
            end else if (ops[0] == 32'h8000_0000 && b == -1) begin
                q = 32'h8000_0000;
                r = 32'h0;
            end else begin
                q = 32'(a / b);
                r = 32'(a % b);
            end
            for (int i = 0; i < 4; i++) resp.push_back(q[8*i +: 8]);
            for (int i = 0; i < 4; i++) resp.push_back(r[8*i +: 8]);
            return;
        end
        acc = ops[0];
        for (int unsigned i = 1; i < n; i++) begin
            if (op == 8'hAD) acc = acc + ops[i];
            else if (op == 8'h3B) acc = acc - ops[i];
            else acc = acc * ops[i];
        end
        for (int i = 0; i < 4; i++) resp.push_back(acc[8*i +: 8]);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t;
        bit rdy;
        repeat ($urandom_range(0, 1)) begin
            axis_if.s_axis_tvalid = 1'b0;
            axis_if.s_axis_tdata  = 8'($urandom);
            @(posedge clk); #1;
        end
        axis_if.s_axis_tdata  = b;
        axis_if.s_axis_tvalid = 1'b1;
        t = 0;
        forever begin
            rdy = axis_if.s_axis_tready;
            @(posedge clk); #1;
            if (rdy) break;
            t++;
            if (t > 100) begin
                check("tready_wait", axis_if.s_axis_tready, 1'b1);
                break;
            end
        end
        axis_if.s_axis_tvalid = 1'b0;
    endtask

    task automatic recv_byte(input int limit, input int stall, output logic [7:0] d_out);
        int         t;
        bit         rdy;
        logic [7:0] hd;
        d_out = 8'hxx;
        axis_if.m_axis_tready = 1'b0;
        t = 0;
        while (axis_if.m_axis_tvalid !== 1'b1) begin
            @(posedge clk); #1;
            t++;
            if (t > limit) begin
                check("valid_wait", axis_if.m_axis_tvalid, 1'b1);
                return;
            end
        end
        hd = axis_if.m_axis_tdata;
        repeat (stall) begin
            @(posedge clk); #1;
            check("stall_hold", {axis_if.m_axis_tvalid, axis_if.m_axis_tdata}, {1'b1, hd});
        end
        t = 0;
        forever begin
            rdy = ($urandom_range(0, 2) != 0);
            axis_if.m_axis_tready = rdy;
            check("resp_hold", {axis_if.m_axis_tvalid, axis_if.m_axis_tdata, axis_if.s_axis_tready},
                  {1'b1, hd, 1'b0});
            @(posedge clk); #1;
            if (rdy) break;
            t++;
            if (t > 100) break;
        end
        axis_if.m_axis_tready = 1'b0;
        d_out = hd;
    endtask

    task automatic run_packet(input string tag, input logic [7:0] op, input logic [7:0] rsv,
                              input logic [15:0] len, input q32_t ops, input int stall);
        bit          len_ok;
        bit          is_div;
        q8_t         exp;
        logic [7:0]  got;
        logic [31:0] w;
        model(op, rsv, len, ops, len_ok, exp);
        is_div = (exp.size() == 8);
        send_byte(op);
        send_byte(rsv);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        if (len_ok) begin
            for (int i = 0; i < int'((len - 4) / B); i++) begin
                w = ops[i];
                for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
            end
        end
        if (!is_div) check({tag, "_lat"}, axis_if.m_axis_tvalid, 1'b1);
        for (int i = 0; i < exp.size(); i++) begin
            recv_byte((i == 0 && is_div) ? int'(W + 4) : 100, (i == 1) ? stall : 0, got);
            check($sformatf("%s_b%0d", tag, i), got, exp[i]);
        end
        check({tag, "_idle"}, {busy, axis_if.s_axis_tready, axis_if.m_axis_tvalid}, 3'b010);
    endtask

    initial begin
        q32_t        ops;
        logic [7:0]  op;
        logic [7:0]  rsv;
        logic [15:0] len;
        int unsigned n;
        bit          seen;

        axis_if.s_axis_tdata  = 8'h00;
        axis_if.s_axis_tvalid = 1'b0;
        axis_if.m_axis_tready = 1'b0;
        #3;
        check("rst_outputs", {axis_if.s_axis_tready, axis_if.m_axis_tvalid, busy, axis_if.m_axis_tdata}, 11'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("tready_after_rst", {axis_if.s_axis_tready, busy}, 2'b10);

        ops = {32'd1, 32'd2};
        run_packet("add12", 8'hAD, 8'h00, 16'h000C, ops, 0);
        ops = {32'h0001_0001, 32'h0001_0001};
        run_packet("mul", 8'h63, 8'h00, 16'h000C, ops, 0);
        ops = {32'hFFFF_FFF9, 32'd2};
        run_packet("div_m7_2", 8'h5B, 8'h00, 16'h000C, ops, 0);
        ops = {32'd5, 32'd0};
        run_packet("div_by0", 8'h5B, 8'h00, 16'h000C, ops, 0);
        ops = {32'h8000_0000, 32'hFFFF_FFFF};
        run_packet("div_ovf", 8'h5B, 8'h00, 16'h000C, ops, 0);
        ops = {32'd100, 32'hFFFF_FFF9, 32'd3};
        run_packet("div_len3", 8'h5B, 8'h00, 16'h0010, ops, 0);

        ops = {32'hDEAD_BEEF, 32'h1234_5678};
        run_packet("unk_op", 8'h11, 8'h00, 16'h000C, ops, 0);
        ops = {};
        run_packet("bad_len6", 8'hAD, 8'h00, 16'h0006, ops, 0);
        ops = {32'hFFFF_FFFF, 32'd7};
        run_packet("add_after", 8'hAD, 8'h00, 16'h000C, ops, 0);
        ops = {32'd10, 32'd3, 32'd4};
        run_packet("rsv_bad", 8'h3B, 8'h01, 16'h0010, ops, 0);
        ops = {32'd10, 32'd3, 32'd20};
        run_packet("sub3", 8'h3B, 8'h00, 16'h0010, ops, 0);
        ops = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'hFFFF_FFF0};
        run_packet("add_max", 8'hAD, 8'h00, 16'h001C, ops, 0);
        run_packet("len_over", 8'hAD, 8'h00, 16'h0020, ops, 0);
        run_packet("len_n1", 8'h63, 8'h00, 16'h0008, ops, 0);
        run_packet("len_hi", 8'hAD, 8'h00, 16'h010C, ops, 0);
        ops = {32'h0000_1003, 32'h0002_0001, 32'hFFFF_FFFD, 32'd9};
        run_packet("mul_stall", 8'h63, 8'h00, 16'h0014, ops, 20);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 5))
                0:       op = 8'hAD;
                1:       op = 8'h3B;
                2:       op = 8'h63;
                3:       op = 8'h5B;
                default: op = 8'($urandom);
            endcase
            rsv = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            n   = (op == 8'h5B) ? 2 : $urandom_range(2, MAX);
            len = 16'(4 + n * B);
            if ($urandom_range(0, 7) == 0) len = len + 16'($urandom_range(1, 3));
            ops = {};
            for (int unsigned i = 0; i < n; i++) ops.push_back($urandom);
            if (op == 8'h5B) begin
                case ($urandom_range(0, 3))
                    0:       ops[1] = 32'd0;
                    1:       ops[1] = 32'hFFFF_FFFF;
                    2:       ops[1] = 32'($urandom_range(1, 50));
                    default: ;
                endcase
            end
            run_packet($sformatf("rnd%0d", k), op, rsv, len, ops, 0);
        end

        send_byte(8'hAD);
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
        check("busy_mid", busy, 1'b1);
        rst = 1'b1;
        #2;
        check("rst_mid_outputs", {axis_if.s_axis_tready, axis_if.m_axis_tvalid, busy, axis_if.m_axis_tdata}, 11'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("tready_after_rst2", axis_if.s_axis_tready, 1'b1);
        seen = 1'b0;
        repeat (5) begin
            seen = seen | axis_if.m_axis_tvalid;
            @(posedge clk); #1;
        end
        check("no_resp_after_rst", {seen, busy}, 2'b00);
        ops = {32'h7FFF_FFFF, 32'd1, 32'd2};
        run_packet("add_post_rst", 8'hAD, 8'h00, 16'h0010, ops, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
